// File: rtl/shared_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shared_mem_ctrl
// Desc     : Round-robin multi-port front end to a single BRAM, one transaction
//            at a time; invalidate broadcast on writes when
//            SHARED_MEM_CTRL_INV_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module shared_mem_ctrl #(
    parameter int PORTS      = 2,
    parameter int WIDTH      = 128,
    parameter int SIZE       = 2097152,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LAT     = 1,
    parameter     INIT_FILE  = ""
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            rw_valid,
    input  logic [PORTS-1:0]            rw_we,
    input  logic [PORTS-1:0]            w_ce,
    input  logic [PORTS*ADDR_WIDTH-1:0] rw_addr,
    input  logic [PORTS*(WIDTH/8)-1:0]  w_mask,
    input  logic [PORTS*WIDTH-1:0]      w_data,
    output logic [PORTS-1:0]            rw_ready,
    output logic [WIDTH-1:0]            r_data,
    output logic [PORTS-1:0]            inv_valid,
    output logic [ADDR_WIDTH-1:0]       inv_addr,
    input  logic [PORTS-1:0]            inv_ready
);

    localparam int c_MASKW = WIDTH / 8;
    localparam int c_DEPTH = SIZE / WIDTH;
    localparam int c_LSB   = $clog2(c_MASKW);
    localparam int c_IDXW  = $clog2(c_DEPTH);
    localparam int c_PW    = (PORTS > 1) ? $clog2(PORTS) : 1;

    // No preload path exists here; the array powers up undefined.
    localparam bit c_unused_init = (INIT_FILE != "");

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_OPER  = 3'd1;
    localparam logic [2:0] c_S_RWAIT = 3'd2;
    localparam logic [2:0] c_S_BCAST = 3'd3;
    localparam logic [2:0] c_S_RESP  = 3'd4;

    logic [2:0]            r_state, w_state_nxt;
    logic [c_PW-1:0]       r_ptr, w_gnt, r_port;
    logic [c_PW:0]         w_j;
    logic                  w_any, w_found;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_MASKW-1:0]    r_mask;
    logic [WIDTH-1:0]      r_wdata;
    logic [1:0]            r_cnt;
    logic [c_IDXW-1:0]     w_idx;
    logic [WIDTH-1:0]      r_mem [c_DEPTH];
    logic [WIDTH-1:0]      r_rd_pipe [RD_LAT];

    assign w_any = |rw_valid;
    assign w_idx = r_addr[c_LSB +: c_IDXW];

    // First requester at or after the pointer, wrapping modulo PORTS.
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int i = 0; i < PORTS; i++) begin
            w_j = {1'b0, r_ptr} + (c_PW+1)'(i);
            if (w_j >= (c_PW+1)'(PORTS))
                w_j = w_j - (c_PW+1)'(PORTS);
            if (!w_found && rw_valid[w_j[c_PW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_j[c_PW-1:0];
            end
        end
    end

`ifdef SHARED_MEM_CTRL_INV_EN
    logic             r_ce;
    logic [PORTS-1:0] r_board, w_board_nxt;

    always_comb begin
        inv_valid   = '0;
        inv_addr    = '0;
        if (r_state == c_S_BCAST) begin
            inv_valid = ~r_board;
            inv_addr  = r_addr;
        end
        w_board_nxt = r_board | (inv_valid & inv_ready);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_board <= '0;
        else if (r_state == c_S_OPER && r_we && r_ce)
            r_board <= PORTS'(1) << r_port;
        else if (r_state == c_S_BCAST)
            r_board <= w_board_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst && r_state == c_S_IDLE && w_any)
            r_ce <= w_ce[w_gnt];
    end
`else
    logic w_unused;
    assign inv_valid = '0;
    assign inv_addr  = '0;
    assign w_unused  = ^{w_ce, inv_ready, r_addr};
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (w_any) w_state_nxt = c_S_OPER;
            c_S_OPER: begin
                if (!r_we)
                    w_state_nxt = c_S_RWAIT;
`ifdef SHARED_MEM_CTRL_INV_EN
                else if (r_ce)
                    w_state_nxt = c_S_BCAST;
`endif
                else
                    w_state_nxt = c_S_RESP;
            end
            c_S_RWAIT: if (r_cnt == 2'(RD_LAT - 1)) w_state_nxt = c_S_RESP;
`ifdef SHARED_MEM_CTRL_INV_EN
            c_S_BCAST: if (&w_board_nxt) w_state_nxt = c_S_RESP;
`else
            c_S_BCAST: w_state_nxt = c_S_IDLE;
`endif
            c_S_RESP:  w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        rw_ready = '0;
        if (r_state == c_S_RESP)
            rw_ready = PORTS'(1) << r_port;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_ptr   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_S_IDLE && w_any) begin
                r_port  <= w_gnt;
                r_we    <= rw_we[w_gnt];
                r_addr  <= rw_addr[int'(w_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
                r_mask  <= w_mask[int'(w_gnt)*c_MASKW +: c_MASKW];
                r_wdata <= w_data[int'(w_gnt)*WIDTH +: WIDTH];
                r_ptr   <= (w_gnt == c_PW'(PORTS - 1)) ? '0 : w_gnt + 1'b1;
            end
            if (r_state == c_S_OPER)
                r_cnt <= '0;
            else if (r_state == c_S_RWAIT)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == c_S_RWAIT && w_state_nxt == c_S_RESP)
                r_data <= r_rd_pipe[RD_LAT-1];
        end
    end

    // Storage is never reset; a write issued in OPER stands even if reset follows.
    always_ff @(posedge clk) begin
        if (r_state == c_S_OPER && r_we) begin
            for (int b = 0; b < c_MASKW; b++)
                if (r_mask[b])
                    r_mem[w_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
    end

    // Stage 0 captures only in OPER, so later stages settle on that word.
    always_ff @(posedge clk) begin
        if (r_state == c_S_OPER)
            r_rd_pipe[0] <= r_mem[w_idx];
        for (int s = 1; s < RD_LAT; s++)
            r_rd_pipe[s] <= r_rd_pipe[s-1];
    end

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_ctrl.sv
`default_nettype none
// Testbench for shared_mem_ctrl: request rounds are resolved against a
// grant-order memory model; a monitor pops expectations on each rw_ready.
module tb_shared_mem_ctrl;
    localparam int c_PORTS  = 2;
    localparam int c_WIDTH  = 32;
    localparam int c_SIZE   = 2048;
    localparam int c_AW     = 16;
    localparam int c_RD_LAT = 3;
    localparam int c_MASKW  = c_WIDTH / 8;
    localparam int c_DEPTH  = c_SIZE / c_WIDTH;
    localparam int c_LSB    = 2;

    typedef struct {
        int               port;
        bit               rd;
        logic [c_WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    typedef struct {
        bit                 we;
        bit                 ce;
        logic [c_AW-1:0]    addr;
        logic [c_MASKW-1:0] mask;
        logic [c_WIDTH-1:0] data;
    } req_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [c_PORTS-1:0]         rw_valid  = '0;
    logic [c_PORTS-1:0]         rw_we     = '0;
    logic [c_PORTS-1:0]         w_ce      = '0;
    logic [c_PORTS*c_AW-1:0]    rw_addr   = '0;
    logic [c_PORTS*c_MASKW-1:0] w_mask    = '0;
    logic [c_PORTS*c_WIDTH-1:0] w_data    = '0;
    logic [c_PORTS-1:0]         inv_ready = '1;
    logic [c_PORTS-1:0]         rw_ready;
    logic [c_WIDTH-1:0]         r_data;
    logic [c_PORTS-1:0]         inv_valid;
    logic [c_AW-1:0]            inv_addr;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [c_WIDTH-1:0] mdl_mem [c_DEPTH];
    int   mdl_ptr = 0;
    int   inv_cnt0 = 0, inv_cnt1 = 0, inv_viol = 0;
    logic [c_AW-1:0] inv_last_addr = '0;

    shared_mem_ctrl #(
        .PORTS(c_PORTS), .WIDTH(c_WIDTH), .SIZE(c_SIZE),
        .ADDR_WIDTH(c_AW), .RD_LAT(c_RD_LAT), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst(rst),
        .rw_valid(rw_valid), .rw_we(rw_we), .w_ce(w_ce),
        .rw_addr(rw_addr), .w_mask(w_mask), .w_data(w_data),
        .rw_ready(rw_ready), .r_data(r_data),
        .inv_valid(inv_valid), .inv_addr(inv_addr), .inv_ready(inv_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor: every completion must match the oldest expectation.
    always @(negedge clk) begin
        if (rw_ready != '0) begin
            check("sb_nonempty", sb_q.size() != 0, 64'(rw_ready), 64'(0));
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("ready_port", rw_ready == c_PORTS'(1 << mon_e.port),
                      64'(rw_ready), 64'(1 << mon_e.port));
                check("ready_cycle", cyc == mon_e.cyc, 64'(cyc), 64'(mon_e.cyc));
                if (mon_e.rd)
                    check("read_data", r_data == mon_e.data, 64'(r_data), 64'(mon_e.data));
            end
        end
        if (!rst) begin
            if (inv_valid == '0 && inv_addr != '0) inv_viol++;
`ifndef SHARED_MEM_CTRL_INV_EN
            if (inv_valid != '0) inv_viol++;
`endif
            if (inv_valid[0]) inv_cnt0++;
            if (inv_valid[1]) inv_cnt1++;
            if (inv_valid != '0) inv_last_addr = inv_addr;
        end
    end

    function automatic req_t mk(input bit we, input bit ce, input logic [c_AW-1:0] addr,
                                input logic [c_MASKW-1:0] mask, input logic [c_WIDTH-1:0] data);
        req_t r;
        r.we = we; r.ce = ce; r.addr = addr; r.mask = mask; r.data = data;
        return r;
    endfunction

    // Call at posedge+1; inv_ready is low until cycle t0+ack_off when ack_off>0.
    task automatic run_round(input req_t rq [c_PORTS], input logic [c_PORTS-1:0] en,
                             input int ack_off);
        int t0, t, k, idx, dur, st, ackc, last, budget;
        logic [c_PORTS-1:0] pend, seen;
        exp_t e;
        t0 = cyc; t = cyc; last = mdl_ptr;
        for (int n = 0; n < c_PORTS; n++) begin
            k = (mdl_ptr + n) % c_PORTS;
            if (en[k]) begin
                idx = (int'(rq[k].addr) >> c_LSB) % c_DEPTH;
                e.port = k; e.rd = !rq[k].we; e.data = '0;
                if (rq[k].we) begin
                    for (int b = 0; b < c_MASKW; b++)
                        if (rq[k].mask[b]) mdl_mem[idx][b*8 +: 8] = rq[k].data[b*8 +: 8];
                    dur = 2;
`ifdef SHARED_MEM_CTRL_INV_EN
                    if (rq[k].ce) begin
                        st   = t + 2;
                        ackc = (ack_off == 0 || t0 + ack_off < st) ? st : t0 + ack_off;
                        dur  = 2 + (ackc - st + 1);
                    end
`endif
                end else begin
                    e.data = mdl_mem[idx];
                    dur = 2 + c_RD_LAT;
                end
                e.cyc = t + dur;
                sb_q.push_back(e);
                t = t + dur + 1;
                last = k;
            end
        end
        mdl_ptr = (last + 1) % c_PORTS;
        for (int p = 0; p < c_PORTS; p++) begin
            if (en[p]) begin
                rw_we[p] = rq[p].we;
                w_ce[p]  = rq[p].ce;
                rw_addr[p*c_AW +: c_AW]        = rq[p].addr;
                w_mask[p*c_MASKW +: c_MASKW]   = rq[p].mask;
                w_data[p*c_WIDTH +: c_WIDTH]   = rq[p].data;
            end
        end
        inv_ready = (ack_off == 0) ? '1 : '0;
        rw_valid  = en;
        pend = en; budget = 0;
        while (pend != '0 && budget < 400) begin
            @(negedge clk);
            seen = rw_ready & pend;
            @(posedge clk); #1;
            if (ack_off != 0 && cyc >= t0 + ack_off) inv_ready = '1;
            rw_valid = rw_valid & ~seen;
            pend = pend & ~seen;
            budget++;
        end
        check("round_done", pend == '0, 64'(pend), 64'(0));
        rw_valid  = '0;
        inv_ready = '1;
    endtask

    task automatic one(input int port, input req_t r, input int ack_off);
        req_t rq [c_PORTS];
        for (int p = 0; p < c_PORTS; p++) rq[p] = mk(0, 0, '0, '0, '0);
        rq[port] = r;
        run_round(rq, c_PORTS'(1 << port), ack_off);
    endtask

    task automatic pair(input req_t a, input req_t b);
        req_t rq [c_PORTS];
        rq[0] = a; rq[1] = b;
        run_round(rq, 2'b11, 0);
    endtask

    initial begin
        req_t rq [c_PORTS];
        logic [c_PORTS-1:0] en;
        logic [c_WIDTH-1:0] v;
        int exp_inv0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_rw_ready", rw_ready == '0, 64'(rw_ready), 64'(0));
        check("rst_inv_valid", inv_valid == '0, 64'(inv_valid), 64'(0));
        check("rst_inv_addr", inv_addr == '0, 64'(inv_addr), 64'(0));
        check("rst_r_data", r_data == '0, 64'(r_data), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Give every word a defined value so any later read has a known answer.
        for (int w = 0; w < c_DEPTH; w += 2)
            pair(mk(1, 0, 16'(w * 4), '1, $urandom), mk(1, 0, 16'((w + 1) * 4), '1, $urandom));

        one(0, mk(1, 0, 16'h0010, 4'hF, 32'hA5A5_A5A5), 0);
        one(0, mk(0, 0, 16'h0010, 4'h0, '0), 0);

        one(1, mk(1, 0, 16'h0020, 4'hF, 32'h0000_0000), 0);
        one(1, mk(1, 0, 16'h0020, 4'h1, 32'hFFFF_FFFF), 0);
        one(1, mk(0, 0, 16'h0020, 4'h0, '0), 0);

        v = $urandom;
        one(0, mk(1, 0, 16'h0030, 4'hF, v), 0);
        one(1, mk(0, 0, 16'hF030, 4'h0, '0), 0);
        one(0, mk(1, 0, 16'h0030, 4'h0, ~v), 0);
        one(0, mk(0, 0, 16'h8130, 4'h0, '0), 0);

        for (int r = 0; r < 4; r++)
            pair(mk(0, 0, 16'h0010, 0, 0), mk(0, 0, 16'h0020, 0, 0));

        inv_cnt0 = 0; inv_cnt1 = 0;
        one(1, mk(1, 1, 16'h0044, 4'hF, 32'h1234_5678), 7);
`ifdef SHARED_MEM_CTRL_INV_EN
        exp_inv0 = 6;
        check("inv_addr_bcast", inv_last_addr == 16'h0044, 64'(inv_last_addr), 64'h44);
`else
        exp_inv0 = 0;
`endif
        check("inv_valid0_cycles", inv_cnt0 == exp_inv0, 64'(inv_cnt0), 64'(exp_inv0));
        check("inv_valid1_cycles", inv_cnt1 == 0, 64'(inv_cnt1), 64'(0));
        one(0, mk(0, 0, 16'h0044, 0, 0), 0);

        for (int r = 0; r < 150; r++) begin
            en = c_PORTS'($urandom_range(1, 3));
            for (int p = 0; p < c_PORTS; p++)
                rq[p] = mk(1'($urandom), 1'($urandom), 16'($urandom), 4'($urandom), $urandom);
            run_round(rq, en, 0);
        end

        // Reset in the first RWAIT cycle of a port0 read must abort it silently.
        rw_we[0] = 1'b0;
        rw_addr[0 +: c_AW] = 16'h0010;
        rw_valid = 2'b01;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rw_valid = '0;
        @(negedge clk);
        check("abort_ready_low", rw_ready == '0, 64'(rw_ready), 64'(0));
        check("abort_rdata_clear", r_data == '0, 64'(r_data), 64'(0));
        repeat (5) begin @(posedge clk); #1; end
        mdl_ptr = 0;
        pair(mk(0, 0, 16'h0010, 0, 0), mk(0, 0, 16'h0030, 0, 0));

        repeat (3) begin @(posedge clk); #1; end
        check("inv_idle_zero", inv_viol == 0, 64'(inv_viol), 64'(0));
        check("sb_drained", sb_q.size() == 0, 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shared_mem_ctrl.md
SHARED_MEM_CTRL -- requirements
Module: shared_mem_ctrl

Interface
REQ-001 Parameter PORTS, default 2: number of requester ports, legal range 1..8.
REQ-002 Parameter WIDTH, default 128: data width in bits, a multiple of 8; MASKW = WIDTH/8.
REQ-003 Parameter SIZE, default 2097152: storage size in bits; DEPTH = SIZE/WIDTH words.
REQ-004 Parameter ADDR_WIDTH, default 32: byte address width.
REQ-005 Parameter RD_LAT, default 1: BRAM read latency in cycles, legal range 1..4.
REQ-006 Parameter INIT_FILE, default "": memory init file; an empty string means no init.
REQ-007 Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rw_valid  in  PORTS  per-port request
- rw_we  in  PORTS  per-port write enable (1 = write)
- w_ce  in  PORTS  per-port write requires invalidate broadcast
- rw_addr  in  PORTS*ADDR_WIDTH  per-port byte address
- w_mask  in  PORTS*MASKW  per-port byte write mask
- w_data  in  PORTS*WIDTH  per-port write data
- rw_ready  out  PORTS  per-port one-cycle completion pulse
- r_data  out  WIDTH  read data, shared by all ports
- inv_valid  out  PORTS  per-port invalidate request
- inv_addr  out  ADDR_WIDTH  invalidate address, shared
- inv_ready  in  PORTS  per-port invalidate acknowledge

Function
REQ-008 The block SHALL serve exactly one transaction, read or write, at a time, so all transactions complete in grant order.
REQ-009 The requester SHALL hold rw_valid and all request fields stable until its rw_ready; any other behaviour is a protocol violation with undefined result.
REQ-010 FSM states SHALL be IDLE, OPER, RWAIT, BCAST and RESP.
- IDLE->OPER when any rw_valid is set.
- OPER->RWAIT for a read.
- OPER->BCAST for a write with w_ce set.
- OPER->RESP for any other write.
- RWAIT->RESP after RD_LAT cycles.
- BCAST->RESP when the scoreboard is full.
- RESP->IDLE always.
REQ-011 Arbitration SHALL be round-robin with pointer ptr, reset 0: grant the first valid port at or after ptr (modulo PORTS); on grant of port k, ptr <= (k+1) mod PORTS.
REQ-012 The granted port index, we, w_ce, addr, mask and data SHALL be latched on the IDLE->OPER edge; later input changes SHALL NOT affect the transaction.
REQ-013 The word index SHALL be addr[LSB +: log2(DEPTH)] with LSB = log2(MASKW); upper address bits are ignored, so addresses wrap.
REQ-014 Write: in OPER, only the bytes whose w_mask bit is set SHALL be written; a mask of 0 writes nothing but still completes.
REQ-015 Read: the BRAM read SHALL issue in OPER; r_data SHALL be registered, valid during RESP, and held until the next read completes.
REQ-016 Latency, with valid first seen in IDLE at cycle t:
- Read rw_ready SHALL pulse at cycle t+2+RD_LAT.
- Write rw_ready without broadcast SHALL pulse at cycle t+2.
REQ-017 rw_ready SHALL be high only in RESP, for exactly one cycle, and only on the granted port.
REQ-018 BCAST: a scoreboard SHALL be preset with the writer's bit set and all other bits clear.
- inv_valid[i] = !board[i] for each port i.
- inv_addr = the latched address.
- board[i] sets on inv_valid[i] && inv_ready[i].
- Exit when board is all ones, evaluated at the end of each BCAST cycle, so the minimum time in BCAST is 1 cycle (also the case for PORTS=1).
REQ-019 Outside BCAST, inv_valid SHALL be 0 and inv_addr SHALL be 0.
REQ-020 A read of the same word issued after a write's rw_ready SHALL return the new data.

Reset
REQ-021 On rst, state, ptr, board and r_data SHALL clear, and rw_ready and inv_valid SHALL go to 0 the following cycle.
REQ-022 Reset mid-transaction SHALL abort it with no rw_ready; a write already performed in OPER is not rolled back; memory contents are otherwise retained.

Configuration
REQ-023 With macro SHARED_MEM_CTRL_INV_EN defined, BCAST and the invalidate logic SHALL be implemented as specified.
REQ-024 Without SHARED_MEM_CTRL_INV_EN, w_ce and inv_ready SHALL be ignored, inv_valid and inv_addr SHALL be constant 0, every write SHALL go OPER->RESP, and BCAST SHALL be unreachable.

Verification
REQ-025 PORTS=2, RD_LAT=1: port0 writes addr 0x10, data 0xA5.., mask all ones, w_ce=0 -> rw_ready[0] at t+2; port0 then reads 0x10 -> r_data 0xA5.. with rw_ready[0] at t+3.
REQ-026 Both ports hold reads continuously from reset -> grants alternate 0,1,0,1; no port waits more than one transaction.
REQ-027 Port1 writes with w_ce=1, inv_ready[0] held 0 for 5 cycles, then 1 -> inv_valid[0] high for 6 cycles; inv_valid[1] never high; rw_ready[1] one cycle after the ack.
REQ-028 Mask 0x0001 write of 0xFF.. over a word holding 0x00.. -> a read returns 0x00..00FF.
REQ-029 RD_LAT=3 and an address with bits above the index set -> rw_ready at t+5 with data of the aliased word.
REQ-030 rst asserted during RWAIT -> no rw_ready; the FSM is in IDLE and ptr=0 one cycle after rst deasserts.
